// File: rtl/vga_clk_synth.sv
// vga_clk_synth: multi-channel phase-accumulator clock-enable synthesizer.
// Define VGA_CLK_PHASE_EN to add cfg_phase (per-channel accumulator preload).
module vga_clk_synth #(
  parameter int NUM_CLOCKS  = 4,
  parameter int ACC_W       = 32,
  parameter int LOCK_CYCLES = 1024,
  localparam int CHW = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CHW-1:0]        cfg_chan,
  input  logic [ACC_W-1:0]      cfg_inc,
`ifdef VGA_CLK_PHASE_EN
  input  logic [ACC_W-1:0]      cfg_phase,
`endif
  output logic [NUM_CLOCKS-1:0] outclk_en,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic                  locked
);

  localparam int CW = $clog2(LOCK_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    LOCKING,
    LOCKED
  } state_e;

  state_e state_q, state_d, prev_q;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  rdy_q;
  logic [CHW-1:0]        chan_q;
  logic [ACC_W-1:0]      inc_h_q;
`ifdef VGA_CLK_PHASE_EN
  logic [ACC_W-1:0]      phase_h_q;
`endif
  logic                  accept;
  logic                  apply;
  logic                  chan_ok;
  logic                  any_en;
  logic [NUM_CLOCKS-1:0] nz;

  assign accept  = cfg_valid & cfg_ready;
  assign chan_ok = (32'(chan_q) < 32'(NUM_CLOCKS));
  assign any_en  = |nz;

  // state register
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prev_q  <= IDLE;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= 1'b1;
      if (accept) begin
        prev_q <= state_q;
      end
    end
  end

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      chan_q    <= '0;
      inc_h_q   <= '0;
`ifdef VGA_CLK_PHASE_EN
      phase_h_q <= '0;
`endif
    end else if (accept) begin
      chan_q    <= cfg_chan;
      inc_h_q   <= cfg_inc;
`ifdef VGA_CLK_PHASE_EN
      phase_h_q <= cfg_phase;
`endif
    end
  end

  // next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = APPLY;
      end
      LOCKING: begin
        if (accept) begin
          state_d = APPLY;
        end else if (cnt_q == CW'(LOCK_CYCLES - 1)) begin
          state_d = LOCKED;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      LOCKED: begin
        if (accept) state_d = APPLY;
      end
      APPLY: begin
        // dropped request resumes exactly where it left off
        if (!chan_ok) begin
          state_d = prev_q;
        end else begin
          cnt_d   = '0;
          state_d = any_en ? LOCKING : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // outputs
  always_comb begin
    cfg_ready = rdy_q & rst_n & (state_q != APPLY);
    locked    = (state_q == LOCKED);
    apply     = (state_q == APPLY) & chan_ok;
  end

  for (genvar g = 0; g < NUM_CLOCKS; g++) begin : g_ch
    logic [ACC_W-1:0] acc_q, inc_q;
    logic             en_q, clk_q;
    logic [ACC_W:0]   sum_d;
    logic             hit;

    assign sum_d = {1'b0, acc_q} + {1'b0, inc_q};
    assign hit   = apply && (chan_q == CHW'(g));
    assign nz[g] = (chan_q == CHW'(g)) ? (inc_h_q != '0)
                                       : (inc_q != '0);

    always_ff @(posedge refclk) begin
      if (!rst_n) begin
        acc_q <= '0;
        inc_q <= '0;
        en_q  <= 1'b0;
        clk_q <= 1'b0;
      end else if (hit) begin
        inc_q <= inc_h_q;
`ifdef VGA_CLK_PHASE_EN
        acc_q <= phase_h_q;
`else
        acc_q <= '0;
`endif
        en_q  <= 1'b0;
        clk_q <= 1'b0;
      end else if (inc_q == '0) begin
        en_q  <= 1'b0;
        clk_q <= 1'b0;
      end else begin
        acc_q <= sum_d[ACC_W-1:0];
        en_q  <= sum_d[ACC_W];
        clk_q <= sum_d[ACC_W-1];
      end
    end

    assign outclk_en[g] = en_q;
    assign outclk[g]    = clk_q;
  end

endmodule
